// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux
// CHANNELS-input registered multiplexer with built-in arbitration.
// Each input is a valid/ready stream of WIDTH bits. The winner of arbitration
// is captured into a single output register, which drives one downstream
// valid/ready stream. mode selects round-robin (0) or fixed priority (1, ch0
// highest).
//
// Optional feature macro: ARB_LOCK_EN
//   When defined, in_last/out_last ports are added. A transfer with
//   in_last=0 locks the grant to that channel until a transfer with in_last=1.
//
// Handshake semantics (all ports): a word moves across an interface on a
// rising clk edge where valid and ready are both 1. A producer holds valid and
// data stable until that edge. ready never depends on the same interface's
// data. in_ready is one-hot or zero, and it is all-zero while reset_n is low.
//
// SEL_W must equal $clog2(CHANNELS).

module rr_arbiter_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_channel,
    input  logic                      out_ready
`ifdef ARB_LOCK_EN
    ,
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last
`endif
);

    // Round-robin search start. It points at the channel after the last
    // round-robin winner.
    logic [SEL_W-1:0]    ptr;

    // Output register may accept a new word this cycle.
    logic                load;

    // Round-robin candidate.
    logic                rr_found;
    logic [SEL_W-1:0]    rr_idx;

    // Fixed-priority candidate.
    logic                fp_found;
    logic [SEL_W-1:0]    fp_idx;

    // Final arbitration result.
    logic                sel_found;
    logic [SEL_W-1:0]    sel_idx;
    logic [CHANNELS-1:0] grant;
    logic [WIDTH-1:0]    sel_data;
    logic                transfer;
    logic [SEL_W-1:0]    ptr_inc;
    logic                ptr_advance;

`ifdef ARB_LOCK_EN
    // Lock state: the grant is held on lock_ch while locked is set.
    logic                locked;
    logic [SEL_W-1:0]    lock_ch;
`endif

    assign load = ~out_valid | out_ready;

    // Round-robin search: first valid channel at or after ptr, wrapping at CHANNELS-1.
    always_comb begin
        int c;
        rr_found = 1'b0;
        rr_idx   = '0;
        c        = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            c = int'(ptr) + k;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            if (!rr_found && in_valid[c[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = c[SEL_W-1:0];
            end
        end
    end

    // Fixed priority: the lowest-index valid channel wins. The scan runs
    // downward, so the last hit is the lowest index.
    always_comb begin
        fp_found = 1'b0;
        fp_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                fp_found = 1'b1;
                fp_idx   = SEL_W'(i);
            end
        end
    end

    // Choose the winner. An active lock overrides mode and all other valids.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef ARB_LOCK_EN
        if (locked) begin
            sel_found = in_valid[lock_ch];
            sel_idx   = lock_ch;
        end else
`endif
        if (mode) begin
            sel_found = fp_found;
            sel_idx   = fp_idx;
        end else begin
            sel_found = rr_found;
            sel_idx   = rr_idx;
        end
    end

    // One-hot grant, and the data of the granted channel.
    always_comb begin
        grant = '0;
        if (sel_found) begin
            grant[sel_idx] = 1'b1;
        end
        sel_data = in_data[sel_idx*WIDTH +: WIDTH];
    end

    // Ready is gated by load. It is also gated by reset_n, so that nothing
    // is accepted while reset is held. During reset the register is empty,
    // so load alone would be 1.
    assign in_ready = grant & {CHANNELS{load & reset_n}};
    assign transfer = sel_found & load & reset_n;

    assign ptr_inc = (sel_idx == SEL_W'(CHANNELS - 1)) ? '0 : sel_idx + 1'b1;

    // Only round-robin transfers move the pointer. With locking enabled,
    // the pointer moves only on the transfer that closes a locked burst.
`ifdef ARB_LOCK_EN
    assign ptr_advance = transfer & ~mode & in_last[sel_idx];
`else
    assign ptr_advance = transfer & ~mode;
`endif

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (ptr_advance) begin
            ptr <= ptr_inc;
        end
    end

    // Output register. A transfer loads a new word. A load with no transfer
    // empties the register but keeps the last data and channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
        end else if (load) begin
            if (transfer) begin
                out_valid   <= 1'b1;
                out_data    <= sel_data;
                out_channel <= sel_idx;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

`ifdef ARB_LOCK_EN
    // Lock tracking. A non-last transfer locks onto its channel, and a last
    // transfer releases the lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (transfer) begin
            locked  <= ~in_last[sel_idx];
            lock_ch <= sel_idx;
        end
    end

    // out_last travels with out_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_last <= 1'b0;
        end else if (load && transfer) begin
            out_last <= in_last[sel_idx];
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Testbench for rr_arbiter_mux (CHANNELS=4, WIDTH=8).
// It runs directed scenarios first and then randomized traffic. Every cycle
// is compared against a behavioural reference model: a rotated candidate
// list, and an output word that is either present or absent.

module tb_rr_arbiter_mux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    // ---------------- clock / reset ----------------
    logic                      clk      = 1'b0;
    logic                      reset_n  = 1'b0;
    logic                      mode     = 1'b0;
    logic [CHANNELS-1:0]       in_valid = '0;
    logic [CHANNELS*WIDTH-1:0] in_data  = '0;
    logic                      out_ready = 1'b0;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_channel;
`ifdef ARB_LOCK_EN
    logic [CHANNELS-1:0]       in_last = '1;
    logic                      out_last;
`endif

    always #5 clk = ~clk;

    rr_arbiter_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_ready   (out_ready)
`ifdef ARB_LOCK_EN
        ,
        .in_last     (in_last),
        .out_last    (out_last)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_ptr;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_och;

    task automatic model_reset();
        m_ptr = 0;
        m_ov  = 0;
        m_od  = '0;
        m_och = 0;
    endtask

    // The winning channel is the first valid entry in the candidate order.
    // Fixed-priority order is 0..3; round-robin order is rotated by the
    // pointer. The result is -1 when nothing can be accepted.
    function automatic int m_pick(input logic m, input logic [3:0] v, input logic ordy);
        int order[$];
        if (m_ov && !ordy) return -1;
        for (int k = 0; k < CHANNELS; k++) order.push_back(m ? k : (m_ptr + k) % CHANNELS);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return -1;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge. It drives the inputs, checks ready before the
    // edge, advances the model, checks the outputs after the edge, and
    // returns at the next negedge.
    task automatic cycle(input logic m, input logic [3:0] v, input logic [31:0] d, input logic ordy);
        int   win;
        logic ld;
        mode      = m;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        ld  = !m_ov || ordy;
        win = m_pick(m, v, ordy);
        check("in_ready", 32'(in_ready), (win >= 0) ? 32'(1 << win) : 32'd0);
        @(posedge clk);
        if (ld) begin
            if (win >= 0) begin
                m_ov  = 1;
                m_od  = d[win*8 +: 8];
                m_och = win;
                if (!m) m_ptr = (win + 1) % CHANNELS;
            end else begin
                m_ov = 0;
            end
        end
        #1;
        check("out_valid",   32'(out_valid),   32'(m_ov));
        check("out_data",    32'(out_data),    32'(m_od));
        check("out_channel", 32'(out_channel), 32'(m_och));
        @(negedge clk);
    endtask

    // Called at a negedge. It asserts reset asynchronously, checks that the
    // outputs clear, holds reset across one posedge, and releases it at the
    // next negedge.
    task automatic do_reset(input logic [3:0] v);
        reset_n  = 1'b0;
        in_valid = v;
        #1;
        model_reset();
        check("rst_in_ready",    32'(in_ready),    32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_data",    32'(out_data),    32'd0);
        check("rst_out_channel", 32'(out_channel), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_in_ready",  32'(in_ready),  32'd0);
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int          rr_seq[5] = '{0, 1, 2, 3, 0};
    logic [31:0] data_a    = 32'hA3A2A1A0;
    logic [31:0] data_b    = 32'hB3B2B1B0;
    logic [7:0]  held;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset(4'hF);

        // Round-robin fairness: all channels valid, expect 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'hF, data_a, 1'b1);
            check("rr_seq", 32'(out_channel), 32'(rr_seq[i]));
            check("rr_full_rate", 32'(out_valid), 32'd1);
        end

        // Fixed priority: ch1 and ch3 valid, so ch1 wins every time.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b1010, data_a, 1'b1);
            check("fp_data", 32'(out_data), 32'hA1);
        end
        // Drop ch1, so ch3 wins.
        cycle(1'b1, 4'b1000, data_a, 1'b1);
        check("fp_ch3", 32'(out_channel), 32'd3);

        // Backpressure: the word is held for 3 cycles and nothing is accepted.
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'hF, data_b, 1'b0);
            check("bp_hold_data", 32'(out_data), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        // Release: a new word loads in the same cycle (pointer still 1 -> ch1).
        cycle(1'b0, 4'hF, data_b, 1'b1);
        check("bp_release", 32'(out_data), 32'hB1);

        // Wrap/sparse: ch2 moves the pointer to 3, then 0011 gives ch0, then ch1.
        cycle(1'b0, 4'b0100, data_a, 1'b1);
        cycle(1'b0, 4'b0011, data_a, 1'b1);
        check("wrap_ch0", 32'(out_channel), 32'd0);
        cycle(1'b0, 4'b0011, data_a, 1'b1);
        check("wrap_ch1", 32'(out_channel), 32'd1);

        // Idle load: the register empties, and data/channel keep their last values.
        cycle(1'b0, 4'b0000, data_a, 1'b1);
        check("idle_keep_data", 32'(out_data), 32'hA1);

        // Randomized traffic with occasional mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(4'($urandom));
            end else begin
                cycle(1'($urandom_range(0, 3) == 0), 4'($urandom), $urandom,
                      1'($urandom_range(0, 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
